uart_top: RTL and testbench



---
 rtl/uart_top.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_top.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// 8N1 UART loopback: tx engine drives an internal serial line that feeds an
// rx engine through a 2-flop synchroniser. Used as a link-level self-test.

// ---------------------------------------------------------------------------
// TX engine: serialises one byte (start, 8 data LSB first, stop).
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CPB = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       line
);
  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t       state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            bit_end;

  assign bit_end = (cnt == CW'(CPB - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: each non-idle state lasts one bit time (DATA lasts eight)
  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (tx_start) state_nxt = TX_START;
      TX_START: if (bit_end) state_nxt = TX_DATA;
      TX_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = TX_STOP;
      TX_STOP:  if (bit_end) state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  // Datapath: bit timer, shift register and the registered line value.
  // The line is updated on the same edge as the state change, so the start
  // bit goes low on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      line    <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (tx_start) begin
            shreg <= tx_data;
            line  <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_end) begin
            cnt  <= '0;
            line <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              line    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              line    <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) cnt <= '0;
          else         cnt <= cnt + 1'b1;
        end
        default: begin
          cnt  <= '0;
          line <= 1'b1;
        end
      endcase
    end
  end
endmodule

// ---------------------------------------------------------------------------
// RX engine: synchronises the line, finds the start bit centre, then samples
// every bit time. A good stop bit publishes the byte with a one-cycle pulse.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CPB = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  output logic [7:0] rx_data,
  output logic       rx_done
);
  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [1:0]      sync;
  logic            rx_s;
  logic            bit_end;
  logic            half_end;

  assign rx_s     = sync[1];
  assign bit_end  = (cnt == CW'(CPB - 1));
  assign half_end = (cnt == CW'(CPB / 2 - 1));

  // Two-flop synchroniser; resets to idle-high so reset never looks like a start
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], line};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a high line at the start-bit centre is treated as a glitch
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (!rx_s) state_nxt = RX_START;
      RX_START: if (half_end) state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (bit_end) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  // Datapath: timer, sample shifter, published byte and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_START: begin
          if (half_end) cnt <= '0;
          else          cnt <= cnt + 1'b1;
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// ---------------------------------------------------------------------------
// Top: tx engine looped back into rx engine over an internal serial line.
// ---------------------------------------------------------------------------
module uart_top #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_done
);
  logic ser_line;

  uart_tx #(.CPB(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .line     (ser_line)
  );

  uart_rx #(.CPB(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .line    (ser_line),
    .rx_data (rx_data),
    .rx_done (rx_done)
  );
endmodule

// File: tb/tb_uart_top.sv
// Directed loopback bench for uart_top at a reduced bit time (16 clocks/bit).
module tb_uart_top;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int t_acc   = 0;
  int t_done[0:7];
  logic [7:0] rx_log[0:7];

  uart_top #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_done  (rx_done)
  );

  always #5 clk = ~clk;

  // Cycle counter: value equals the number of rising edges seen so far
  always @(posedge clk) cyc++;

  // Monitor: every high sample of rx_done is logged, so a wide pulse counts twice
  always @(negedge clk) begin
    if (rx_done) begin
      if (done_cnt < 8) begin
        t_done[done_cnt] = cyc;
        rx_log[done_cnt] = rx_data;
      end
      done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_rst(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
  endtask

  // Present a byte for exactly one rising edge; t_acc = edge index of acceptance
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    t_acc    = cyc;
    tx_start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] vec [0:3];
  int lat;

  initial begin
    vec[0] = 8'h5E; vec[1] = 8'hA3; vec[2] = 8'hFF; vec[3] = 8'hC7;

    // 1: reset state, then a single 0x00 frame
    repeat (20) @(negedge clk);
    chk("rst_rx_data", {24'h0, rx_data}, 32'h00);
    chk("rst_rx_done", {31'h0, rx_done}, 32'h0);
    chk("rst_line",    {31'h0, u_dut.ser_line}, 32'h1);
    rst = 1'b0;
    done_cnt = 0;
    send(8'h00);
    wait_cyc(FRAME + 20);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_data", {24'h0, rx_data}, 32'h00);

    // 2: each byte after a one-cycle reset
    for (int i = 0; i < 4; i++) begin
      pulse_rst(1);
      chk("t2_rst_data", {24'h0, rx_data}, 32'h00);
      send(vec[i]);
      wait_cyc(FRAME + 20);
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_data", {24'h0, rx_data}, {24'h0, vec[i]});
    end

    // 3: second request mid-frame is dropped
    pulse_rst(1);
    send(8'h5E);
    wait_cyc(3 * CPB);
    tx_data = 8'h11; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_cyc(2 * FRAME);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_data", {24'h0, rx_data}, 32'h5E);

    // 4: tx_start held across two acceptance points -> two back-to-back frames
    pulse_rst(1);
    tx_data = 8'hA3; tx_start = 1'b1;
    wait_cyc(FRAME + 90);
    tx_start = 1'b0;
    wait_cyc(FRAME + 20);
    chk("t4_done_cnt", done_cnt, 2);
    chk("t4_byte0", {24'h0, rx_log[0]}, 32'hA3);
    chk("t4_byte1", {24'h0, rx_log[1]}, 32'hA3);
    chk("t4_gap", t_done[1] - t_done[0], FRAME);

    // 5: reset in the middle of the data bits of 0xC7 (line low on bit 3)
    pulse_rst(1);
    send(8'hC7);
    wait_cyc(4 * CPB + 6);
    chk("t5_line_mid", {31'h0, u_dut.ser_line}, 32'h0);
    pulse_rst(1);
    chk("t5_line_rst", {31'h0, u_dut.ser_line}, 32'h1);
    chk("t5_data_rst", {24'h0, rx_data}, 32'h00);
    wait_cyc(FRAME + 20);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_data_hold", {24'h0, rx_data}, 32'h00);
    send(8'hC7);
    wait_cyc(FRAME + 20);
    chk("t5_resend_cnt", done_cnt, 1);
    chk("t5_resend_data", {24'h0, rx_data}, 32'hC7);

    // 6: latency window and one-cycle pulse for 0xFF
    pulse_rst(1);
    send(8'hFF);
    wait_cyc(FRAME + 20);
    chk("t6_done_cnt", done_cnt, 1);
    lat = t_done[0] - t_acc;
    chk("t6_lat_min", {31'h0, lat >= (19 * CPB) / 2}, 32'h1);
    chk("t6_lat_max", {31'h0, lat <= (19 * CPB) / 2 + 5}, 32'h1);
    chk("t6_data", {24'h0, rx_data}, 32'hFF);
    chk("t6_done_low", {31'h0, rx_done}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
